// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and constants for the sequential signed divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Quotient reported for a zero divisor; replicate bit 0 for other widths.
    localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Brief    : Start/busy/done handshake and operand/result bus of the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
    parameter int WIDTH = div_pkg::DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : seq_divider_if
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_step
// Brief    : One combinational restoring-division step on magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div_step #(
    parameter int WIDTH = div_pkg::DEFAULT_WIDTH
) (
    input  wire logic [WIDTH:0]   p,
    input  wire logic [WIDTH-1:0] q,
    input  wire logic [WIDTH-1:0] dmag,
    output logic      [WIDTH:0]   p_next,
    output logic      [WIDTH-1:0] q_next
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;
    logic           w_unused_p_msb;

    // P stays below |divisor| between steps, so its MSB never feeds the shift.
    assign w_unused_p_msb = p[WIDTH];
    assign w_shifted      = {p[WIDTH-1:0], q[WIDTH-1]};
    assign w_trial        = w_shifted - {1'b0, dmag};

    always_comb begin
        p_next = w_shifted;
        q_next = {q[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            p_next = w_trial;
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule : seq_div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Radix-2 restoring signed divider, WIDTH+2 cycle fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     rst,
    seq_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    c_LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_DIV0_Q    = {WIDTH{DIV0_QUOTIENT[0]}};

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic             w_accept;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dmag;
    logic [WIDTH-1:0] r_dividend;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dzero;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_p_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_dividend_mag;
    logic [WIDTH-1:0] w_divisor_mag;
    logic [WIDTH-1:0] w_rem_mag;

    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign w_dividend_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_divisor_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign w_rem_mag      = r_p[WIDTH-1:0];

    seq_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p      (r_p),
        .q      (r_q),
        .dmag   (r_dmag),
        .p_next (w_p_next),
        .q_next (w_q_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                    w_accept     = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_p           <= '0;
            r_q           <= '0;
            r_dmag        <= '0;
            r_dividend    <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dzero       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Busy covers the done cycle too, and stays up across a back-to-back start.
            r_busy <= (r_state != IDLE) || w_accept;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_neg_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_neg_r    <= bus.dividend[WIDTH-1];
                        r_dzero    <= (bus.divisor == '0);
                        r_dmag     <= w_divisor_mag;
                        r_q        <= w_dividend_mag;
                        r_dividend <= bus.dividend;
                        r_p        <= '0;
                        r_cnt      <= '0;
                    end
                end
                RUN: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_dzero) begin
                        r_quotient    <= c_DIV0_Q;
                        r_remainder   <= r_dividend;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= r_neg_q ? -r_q : r_q;
                        r_remainder   <= r_neg_r ? -w_rem_mag : w_rem_mag;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule : seq_divider
`default_nettype wire
